// File: rtl/memory_board_ctrl_pkg.sv
// Shared definitions for the memory game board controller: FSM states and default grid geometry.
package memory_board_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FIRST  = 3'd1,
    ST_RD1    = 3'd2,
    ST_SECOND = 3'd3,
    ST_RD2    = 3'd4,
    ST_CMP    = 3'd5,
    ST_HOLD   = 3'd6,
    ST_DONE   = 3'd7
  } state_t;

  localparam int POS_W          = 12;
  localparam int MOVES_W        = 16;
  localparam int DEF_GRID_X     = 4;
  localparam int DEF_GRID_Y     = 3;
  localparam int DEF_ORIGIN_X   = 62;
  localparam int DEF_ORIGIN_Y   = 44;
  localparam int DEF_CARD_W     = 200;
  localparam int DEF_CARD_H     = 200;
  localparam int DEF_GAP        = 20;
  localparam int DEF_COLOR_W    = 12;
  localparam int DEF_HIDE_DELAY = 65_000_000;

endpackage

// File: rtl/memory_board_ctrl_card_hit_decoder.sv
// Combinational hit test: registered mouse position -> {hit, card index}; gaps and off-grid miss.
module card_hit_decoder
  import memory_board_ctrl_pkg::*;
#(
  parameter int GRID_X   = DEF_GRID_X,
  parameter int GRID_Y   = DEF_GRID_Y,
  parameter int ORIGIN_X = DEF_ORIGIN_X,
  parameter int ORIGIN_Y = DEF_ORIGIN_Y,
  parameter int CARD_W   = DEF_CARD_W,
  parameter int CARD_H   = DEF_CARD_H,
  parameter int GAP      = DEF_GAP,
  parameter int AW       = 4
) (
  input  logic [POS_W-1:0] x,
  input  logic [POS_W-1:0] y,
  output logic             hit,
  output logic [AW-1:0]    idx
);

  logic [31:0]       x_ext;
  logic [31:0]       y_ext;
  logic [GRID_X-1:0] col_hit;
  logic [GRID_Y-1:0] row_hit;
  logic              col_ok;
  logic              row_ok;
  int                col_i;
  int                row_i;

  assign x_ext = {{(32-POS_W){1'b0}}, x};
  assign y_ext = {{(32-POS_W){1'b0}}, y};

  // One window comparator per column and per row; at most one of each can fire.
  genvar gi;
  generate
    for (gi = 0; gi < GRID_X; gi++) begin : g_col
      localparam logic [31:0] LO = 32'(ORIGIN_X + gi * (CARD_W + GAP));
      assign col_hit[gi] = (x_ext >= LO) && (x_ext < LO + 32'(CARD_W));
    end
    for (gi = 0; gi < GRID_Y; gi++) begin : g_row
      localparam logic [31:0] LO = 32'(ORIGIN_Y + gi * (CARD_H + GAP));
      assign row_hit[gi] = (y_ext >= LO) && (y_ext < LO + 32'(CARD_H));
    end
  endgenerate

  always_comb begin
    col_i  = 0;
    row_i  = 0;
    col_ok = 1'b0;
    row_ok = 1'b0;
    for (int i = 0; i < GRID_X; i++) begin
      if (col_hit[i]) begin
        col_i  = i;
        col_ok = 1'b1;
      end
    end
    for (int i = 0; i < GRID_Y; i++) begin
      if (row_hit[i]) begin
        row_i  = i;
        row_ok = 1'b1;
      end
    end
    hit = col_ok & row_ok;
    idx = AW'(row_i * GRID_X + col_i);
  end

endmodule

// File: rtl/memory_board_ctrl.sv
// Memory game board controller: reveal two cards, compare colours, keep or hide the pair.
// Optional MOVE_COUNTER_EN builds a saturating pair-attempt counter on the moves output.
module memory_board_ctrl
  import memory_board_ctrl_pkg::*;
#(
  parameter int GRID_X     = DEF_GRID_X,
  parameter int GRID_Y     = DEF_GRID_Y,
  parameter int ORIGIN_X   = DEF_ORIGIN_X,
  parameter int ORIGIN_Y   = DEF_ORIGIN_Y,
  parameter int CARD_W     = DEF_CARD_W,
  parameter int CARD_H     = DEF_CARD_H,
  parameter int GAP        = DEF_GAP,
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int HIDE_DELAY = DEF_HIDE_DELAY,
  localparam int N         = GRID_X * GRID_Y,
  localparam int AW        = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [POS_W-1:0]   xpos,
  input  logic [POS_W-1:0]   ypos,
  input  logic               left,
  output logic [AW-1:0]      rd_addr,
  input  logic [COLOR_W-1:0] rd_data,
  output logic [N-1:0]       revealed,
  output logic [N-1:0]       matched,
  output logic               game_over,
  output logic [MOVES_W-1:0] moves
);

  localparam int TW = $clog2(HIDE_DELAY + 1);
  localparam logic [N-1:0] ALL_CARDS = {N{1'b1}};

  state_t             state_reg;
  logic               left_reg, left_d_reg;
  logic [POS_W-1:0]   x_reg, y_reg;
  logic [AW-1:0]      rd_addr_reg, idx_a_reg, idx_b_reg;
  logic [N-1:0]       revealed_reg, matched_reg;
  logic               game_over_reg, rd_wait_reg;
  logic [COLOR_W-1:0] col_a_reg, col_b_reg;
  logic [TW-1:0]      timer_reg;
  logic               click, hit, pick_ok;
  logic [AW-1:0]      hit_idx;
  logic [N-1:0]       pair_mask;

  card_hit_decoder #(
    .GRID_X(GRID_X), .GRID_Y(GRID_Y), .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y),
    .CARD_W(CARD_W), .CARD_H(CARD_H), .GAP(GAP), .AW(AW)
  ) u_hit (
    .x  (x_reg),
    .y  (y_reg),
    .hit(hit),
    .idx(hit_idx)
  );

  assign click     = left_reg & ~left_d_reg;
  assign pick_ok   = click & hit & ~revealed_reg[hit_idx] & ~matched_reg[hit_idx];
  assign pair_mask = (N'(1) << idx_a_reg) | (N'(1) << idx_b_reg);

`ifdef MOVE_COUNTER_EN
  logic [MOVES_W-1:0] moves_reg;
  assign moves = moves_reg;
`else
  assign moves = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      left_reg      <= 1'b0;
      left_d_reg    <= 1'b0;
      x_reg         <= '0;
      y_reg         <= '0;
      rd_addr_reg   <= '0;
      idx_a_reg     <= '0;
      idx_b_reg     <= '0;
      revealed_reg  <= '0;
      matched_reg   <= '0;
      game_over_reg <= 1'b0;
      rd_wait_reg   <= 1'b0;
      col_a_reg     <= '0;
      col_b_reg     <= '0;
      timer_reg     <= '0;
`ifdef MOVE_COUNTER_EN
      moves_reg     <= '0;
`endif
    end else begin
      left_reg   <= left;
      left_d_reg <= left_reg;
      x_reg      <= xpos;
      y_reg      <= ypos;
      if (!enable) begin
        state_reg     <= ST_IDLE;
        rd_addr_reg   <= '0;
        revealed_reg  <= '0;
        matched_reg   <= '0;
        game_over_reg <= 1'b0;
        rd_wait_reg   <= 1'b0;
        timer_reg     <= '0;
`ifdef MOVE_COUNTER_EN
        moves_reg     <= '0;
`endif
      end else begin
        case (state_reg)
          ST_IDLE: state_reg <= ST_FIRST;
          ST_FIRST, ST_SECOND: begin
            if (pick_ok) begin
              revealed_reg[hit_idx] <= 1'b1;
              rd_addr_reg           <= hit_idx;
              rd_wait_reg           <= 1'b0;
              if (state_reg == ST_FIRST) begin
                idx_a_reg <= hit_idx;
                state_reg <= ST_RD1;
              end else begin
                idx_b_reg <= hit_idx;
                state_reg <= ST_RD2;
              end
            end
          end
          // The regfile answers one cycle after it samples rd_addr, so wait a cycle first.
          ST_RD1, ST_RD2: begin
            if (!rd_wait_reg) begin
              rd_wait_reg <= 1'b1;
            end else begin
              rd_wait_reg <= 1'b0;
              if (state_reg == ST_RD1) begin
                col_a_reg <= rd_data;
                state_reg <= ST_SECOND;
              end else begin
                col_b_reg <= rd_data;
                state_reg <= ST_CMP;
              end
            end
          end
          ST_CMP: begin
`ifdef MOVE_COUNTER_EN
            if (moves_reg != {MOVES_W{1'b1}}) moves_reg <= moves_reg + MOVES_W'(1);
`endif
            if (col_a_reg == col_b_reg) begin
              matched_reg  <= matched_reg | pair_mask;
              revealed_reg <= revealed_reg & ~pair_mask;
              if ((matched_reg | pair_mask) == ALL_CARDS) begin
                state_reg     <= ST_DONE;
                game_over_reg <= 1'b1;
              end else begin
                state_reg <= ST_FIRST;
              end
            end else begin
              timer_reg <= TW'(HIDE_DELAY - 1);
              state_reg <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (timer_reg == '0) begin
              revealed_reg <= revealed_reg & ~pair_mask;
              state_reg    <= ST_FIRST;
            end else begin
              timer_reg <= timer_reg - TW'(1);
            end
          end
          ST_DONE: state_reg <= ST_DONE;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign rd_addr   = rd_addr_reg;
  assign revealed  = revealed_reg;
  assign matched   = matched_reg;
  assign game_over = game_over_reg;

endmodule

// File: tb/tb_memory_board_ctrl.sv
// Self-checking bench for memory_board_ctrl: scenario tasks against a rule-level game model.
module tb_memory_board_ctrl;

  localparam int GX = 4, GY = 3, OX = 62, OY = 44, CW = 200, CH = 200, GAP = 20;
  localparam int HD = 10;
  localparam int N  = GX * GY;
`ifdef MOVE_COUNTER_EN
  localparam bit MC = 1'b1;
`else
  localparam bit MC = 1'b0;
`endif

  logic        clk, rst, enable, left;
  logic [11:0] xpos, ypos;
  logic [3:0]  rd_addr;
  logic [11:0] rd_data;
  logic [N-1:0] revealed, matched;
  logic        game_over;
  logic [15:0] moves;

  logic [11:0] mem [N];
  int          pid [N];

  int errors = 0;
  int checks = 0;

  // Game model state
  logic [N-1:0] exp_rev, exp_mat, pend;
  bit           mdl_done;
  int           phase, first_idx, attempts;

  memory_board_ctrl #(.HIDE_DELAY(HD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .xpos(xpos), .ypos(ypos), .left(left),
    .rd_addr(rd_addr), .rd_data(rd_data), .revealed(revealed), .matched(matched),
    .game_over(game_over), .moves(moves)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  function automatic int cx(input int i); return OX + (i % GX) * (CW + GAP) + CW / 2; endfunction
  function automatic int cy(input int i); return OY + (i / GX) * (CH + GAP) + CH / 2; endfunction

  function automatic int model_hit(input int x, input int y);
    int c, r;
    if (x < OX || y < OY) return -1;
    c = (x - OX) / (CW + GAP);
    r = (y - OY) / (CH + GAP);
    if ((x - OX) % (CW + GAP) >= CW || (y - OY) % (CH + GAP) >= CH) return -1;
    if (c >= GX || r >= GY) return -1;
    return r * GX + c;
  endfunction

  function automatic int partner(input int i);
    for (int j = 0; j < N; j++) if (j != i && mem[j] == mem[i]) return j;
    return -1;
  endfunction

  function automatic logic [15:0] exp_moves();
    return MC ? 16'(attempts) : 16'd0;
  endfunction

  task automatic model_clear();
    exp_rev = '0; exp_mat = '0; pend = '0;
    mdl_done = 1'b0; phase = 0; first_idx = 0; attempts = 0;
  endtask

  task automatic model_click(input int x, input int y);
    int i;
    i = model_hit(x, y);
    if (mdl_done || pend != '0 || i < 0) return;
    if (exp_rev[i] || exp_mat[i]) return;
    exp_rev[i] = 1'b1;
    if (phase == 0) begin
      first_idx = i;
      phase = 1;
    end else begin
      phase = 0;
      attempts++;
      if (mem[first_idx] == mem[i]) begin
        exp_mat[first_idx] = 1'b1; exp_mat[i] = 1'b1;
        exp_rev[first_idx] = 1'b0; exp_rev[i] = 1'b0;
        if (exp_mat == {N{1'b1}}) mdl_done = 1'b1;
      end else begin
        pend = '0; pend[first_idx] = 1'b1; pend[i] = 1'b1;
      end
    end
  endtask

  task automatic settle_hold();
    if (pend != '0) begin
      repeat (HD + 4) @(negedge clk);
      exp_rev = exp_rev & ~pend;
      pend = '0;
    end
  endtask

  task automatic setup_fixed();
    for (int i = 0; i < N; i++) mem[i] = {4'(i), 8'($urandom)};
    mem[5] = mem[0];
  endtask

  task automatic setup_pairs();
    int j, t;
    logic [7:0] r [N/2];
    for (int i = 0; i < N; i++) pid[i] = i / 2;
    for (int i = N - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      t = pid[i]; pid[i] = pid[j]; pid[j] = t;
    end
    for (int p = 0; p < N / 2; p++) r[p] = 8'($urandom);
    for (int i = 0; i < N; i++) mem[i] = {4'(pid[i]), r[pid[i]]};
  endtask

  task automatic restart();
    @(negedge clk); enable = 1'b0; left = 1'b0;
    @(negedge clk); enable = 1'b1;
    repeat (2) @(negedge clk);
    model_clear();
  endtask

  // Returns just after the edge that registers the press; left stays high.
  task automatic press(input int x, input int y);
    @(negedge clk); xpos = 12'(x); ypos = 12'(y); left = 1'b1;
    @(negedge clk);
  endtask

  task automatic click(input int x, input int y);
    press(x, y);
    repeat (2) @(negedge clk);
    left = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; enable = 1'b0; left = 1'b0; xpos = '0; ypos = '0;
    setup_fixed();
    repeat (2) @(negedge clk);
    checks++; if (revealed !== '0 || matched !== '0 || game_over !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: rev=%h mat=%h go=%b required 0", revealed, matched, game_over);
    end
    rst = 1'b1; enable = 1'b1;
    repeat (4) @(negedge clk);
    model_clear();
    checks++; if (revealed !== '0 || matched !== '0) begin
      errors++; $display("FAIL enable_idle: rev=%h mat=%h required 0", revealed, matched);
    end
    checks++; if (game_over !== 1'b0 || moves !== 16'd0 || rd_addr !== 4'd0) begin
      errors++; $display("FAIL enable_idle_misc: go=%b moves=%0d rd_addr=%0d required 0", game_over, moves, rd_addr);
    end
    $display("test_reset done");
  endtask

  task automatic test_match();
    click(100, 100);
    checks++; if (revealed !== 12'h001) begin
      errors++; $display("FAIL match_first_reveal: rev=%h required 001", revealed);
    end
    press(300, 300);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 2) left = 1'b0;
      if (k == 1) begin
        checks++; if (revealed !== 12'h021) begin
          errors++; $display("FAIL match_second_reveal: rev=%h required 021", revealed);
        end
      end
      checks++; if (matched !== ((k < 4) ? 12'h000 : 12'h021)) begin
        errors++; $display("FAIL match_latency k=%0d: mat=%h required %h", k, matched, (k < 4) ? 12'h000 : 12'h021);
      end
    end
    checks++; if (revealed !== 12'h000) begin
      errors++; $display("FAIL match_revealed_clear: rev=%h required 000", revealed);
    end
    $display("test_match done mat=%h", matched);
  endtask

  task automatic test_mismatch_hold();
    logic [N-1:0] e;
    restart();
    click(cx(0), cy(0));
    press(cx(1), cy(1));
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 2) left = 1'b0;
      if (k == 6) begin xpos = 12'(cx(2)); ypos = 12'(cy(2)); left = 1'b1; end
      if (k == 8) left = 1'b0;
      e = (k < 4 + HD) ? 12'h003 : 12'h000;
      checks++; if (revealed !== e) begin
        errors++; $display("FAIL hold_window k=%0d: rev=%h required %h", k, revealed, e);
      end
    end
    // A click landing exactly on hold expiry is dropped.
    click(cx(2), cy(2));
    press(cx(3), cy(3));
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 2) left = 1'b0;
      if (k == 12) begin xpos = 12'(cx(4)); ypos = 12'(cy(4)); left = 1'b1; end
      if (k == 14) left = 1'b0;
      if (k == 13 || k == 16) begin
        e = (k == 13) ? 12'h00C : 12'h000;
        checks++; if (revealed !== e) begin
          errors++; $display("FAIL hold_expiry_click k=%0d: rev=%h required %h", k, revealed, e);
        end
      end
    end
    click(cx(4), cy(4));
    checks++; if (revealed !== 12'h010 || matched !== 12'h000) begin
      errors++; $display("FAIL after_hold_first: rev=%h mat=%h required 010/000", revealed, matched);
    end
    $display("test_mismatch_hold done");
  endtask

  task automatic test_ignored_clicks();
    restart();
    click(270, 100);
    click(5, 5);
    click(cx(0), cy(0));
    click(cx(0), cy(0));
    checks++; if (revealed !== 12'h001 || matched !== 12'h000) begin
      errors++; $display("FAIL ignored_clicks: rev=%h mat=%h required 001/000", revealed, matched);
    end
    click(300, 300);
    checks++; if (matched !== 12'h021 || revealed !== 12'h000) begin
      errors++; $display("FAIL still_second: mat=%h rev=%h required 021/000", matched, revealed);
    end
    $display("test_ignored_clicks done");
  endtask

  task automatic test_full_game();
    int a, b;
    setup_pairs();
    restart();
    for (int p = 0; p < N / 2; p++) begin
      a = -1; b = -1;
      for (int i = 0; i < N; i++) if (pid[i] == p) begin if (a < 0) a = i; else b = i; end
      click(cx(a), cy(a)); model_click(cx(a), cy(a));
      click(cx(b), cy(b)); model_click(cx(b), cy(b));
      checks++; if (matched !== exp_mat) begin
        errors++; $display("FAIL full_game pair %0d: mat=%h required %h", p, matched, exp_mat);
      end
    end
    checks++; if (game_over !== 1'b1 || moves !== exp_moves()) begin
      errors++; $display("FAIL game_end: go=%b moves=%0d required 1/%0d", game_over, moves, exp_moves());
    end
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    checks++; if (revealed !== '0 || matched !== '0 || game_over !== 1'b0 || moves !== 16'd0) begin
      errors++; $display("FAIL disable_clear: rev=%h mat=%h go=%b moves=%0d required 0", revealed, matched, game_over, moves);
    end
    enable = 1'b1;
    $display("test_full_game done moves=%0d", moves);
  endtask

  task automatic test_abort();
    int p, a, b;
    setup_pairs();
    restart();
    p = partner(0);
    a = -1; b = -1;
    for (int i = 1; i < N; i++) if (i != p && a < 0) a = i;
    for (int i = 1; i < N; i++) if (i != p && i != a && b < 0 && mem[i] != mem[a]) b = i;
    click(cx(0), cy(0)); click(cx(p), cy(p));
    click(cx(a), cy(a)); click(cx(b), cy(b));
    checks++; if (revealed !== ((N'(1) << a) | (N'(1) << b))) begin
      errors++; $display("FAIL abort_in_hold: rev=%h required pair %0d,%0d", revealed, a, b);
    end
    @(negedge clk); enable = 1'b0;
    @(negedge clk);
    checks++; if (revealed !== '0 || matched !== '0 || game_over !== 1'b0) begin
      errors++; $display("FAIL enable_drop_hold: rev=%h mat=%h go=%b required 0", revealed, matched, game_over);
    end
    enable = 1'b1; repeat (2) @(negedge clk);
    click(cx(0), cy(0)); click(cx(p), cy(p));
    checks++; if (matched !== ((N'(1) << 0) | (N'(1) << p))) begin
      errors++; $display("FAIL replay_after_disable: mat=%h required cards 0,%0d", matched, p);
    end
    // Reset while the second colour read is in flight.
    click(cx(a), cy(a));
    press(cx(partner(a)), cy(partner(a)));
    @(negedge clk); rst = 1'b0; left = 1'b0;
    @(negedge clk);
    checks++; if (revealed !== '0 || matched !== '0 || rd_addr !== 4'd0 || moves !== 16'd0) begin
      errors++; $display("FAIL reset_in_rd2: rev=%h mat=%h rd_addr=%0d moves=%0d required 0", revealed, matched, rd_addr, moves);
    end
    rst = 1'b1; repeat (3) @(negedge clk);
    click(cx(a), cy(a)); click(cx(partner(a)), cy(partner(a)));
    checks++; if (matched !== ((N'(1) << a) | (N'(1) << partner(a))) || revealed !== '0) begin
      errors++; $display("FAIL replay_after_reset: mat=%h rev=%h", matched, revealed);
    end
    $display("test_abort done");
  endtask

  task automatic test_random();
    int x, y, i;
    setup_pairs();
    restart();
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        i = int'($urandom_range(0, N - 1));
        x = cx(i) + int'($urandom_range(0, 190)) - 95;
        y = cy(i) + int'($urandom_range(0, 190)) - 95;
      end else begin
        x = int'($urandom_range(0, 1100));
        y = int'($urandom_range(0, 760));
      end
      click(x, y);
      model_click(x, y);
      checks++; if (revealed !== exp_rev || matched !== exp_mat || game_over !== mdl_done) begin
        errors++; $display("FAIL random click %0d (%0d,%0d): rev=%h mat=%h go=%b required %h/%h/%b",
                           n, x, y, revealed, matched, game_over, exp_rev, exp_mat, mdl_done);
      end
      if (pend != '0) begin
        settle_hold();
        checks++; if (revealed !== exp_rev) begin
          errors++; $display("FAIL random hide %0d: rev=%h required %h", n, revealed, exp_rev);
        end
      end
    end
    checks++; if (moves !== exp_moves()) begin
      errors++; $display("FAIL random_moves: moves=%0d required %0d", moves, exp_moves());
    end
    $display("test_random done attempts=%0d", attempts);
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch_hold();
    test_ignored_clicks();
    test_full_game();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
